// File: rtl/mgmt_phy_tx_scheduler_pkg.sv
// Purpose : shared types and constants for the LTPI PHY management TX scheduler.
// Contents: rstate_t (PHY controller states), tx_frm_type_t (TX frame kinds),
//           frame length, timeout length and frame-count targets.
package mgmt_phy_tx_scheduler_pkg;

  localparam int unsigned STATE_W     = 4;
  localparam int unsigned FRM_TYPE_W  = 3;
  localparam int unsigned OFFSET_W    = 4;
  localparam int unsigned DETECT_CNT_W = 8;
  localparam int unsigned SPEED_CNT_W  = 3;
  localparam int unsigned TMO_CNT_W    = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT                       = 4'd0,
    ST_COMMA_HUNTING              = 4'd1,
    ST_WAIT_LINK_DETECT_LOCKED    = 4'd2,
    ST_WAIT_LINK_SPEED_LOCKED     = 4'd3,
    ST_LINK_SPEED_CHANGE          = 4'd4,
    ST_WAIT_LINK_ADVERTISE_LOCKED = 4'd5,
    ST_WAIT_IN_ADVERTISE          = 4'd6,
    ST_CONFIGURATION_OR_ACCEPT    = 4'd7,
    ST_OPERATIONAL                = 4'd8,
    ST_OPERATIONAL_RESET          = 4'd9,
    ST_LINK_LOST_ERR              = 4'd10
  } rstate_t;

  typedef enum logic [FRM_TYPE_W-1:0] {
    FRM_DETECT      = 3'd0,
    FRM_SPEED       = 3'd1,
    FRM_ADVERTISE   = 3'd2,
    FRM_CONFIGURE   = 3'd3,
    FRM_OPERATIONAL = 3'd4,
    FRM_IDLE        = 3'd5
  } tx_frm_type_t;

  // Offset of the last byte of a TX frame
  localparam logic [OFFSET_W-1:0]     frame_length     = 4'd15;
  // 1 ms at 60 MHz
  localparam logic [TMO_CNT_W-1:0]    TIMER_1MS_60MHZ  = 16'd60000;
  localparam logic [DETECT_CNT_W-1:0] DETECT_TX_TARGET = 8'd255;
  localparam logic [SPEED_CNT_W-1:0]  SPEED_TX_TARGET  = 3'd7;

endpackage

// File: rtl/mgmt_phy_tx_scheduler_if.sv
// Purpose : link-state / framer-side bundle of the TX scheduler.
// slave  : scheduler side (consumes state, offset, lock; produces frame
//          type, sw-reset bit, boundary, counters and flags).
// master : controller/framer side, the mirror image.
interface mgmt_phy_tx_scheduler_if;
  import mgmt_phy_tx_scheduler_pkg::*;

  rstate_t                 LTPI_link_ST;
  logic [OFFSET_W-1:0]     tx_frm_offset;
  logic                    link_detect_locked;
  tx_frm_type_t            tx_frame_type;
  logic                    tx_frame_sw_reset;
  logic                    frame_boundary;
  logic [DETECT_CNT_W-1:0] detect_frm_cnt;
  logic [SPEED_CNT_W-1:0]  speed_frm_cnt;
  logic                    transmited_255_detect_frm;
  logic                    transmited_7_speed_frm;
  logic                    link_speed_timeout_detect;

  modport slave (
    input  LTPI_link_ST, tx_frm_offset, link_detect_locked,
    output tx_frame_type, tx_frame_sw_reset, frame_boundary,
           detect_frm_cnt, speed_frm_cnt,
           transmited_255_detect_frm, transmited_7_speed_frm,
           link_speed_timeout_detect
  );

  modport master (
    output LTPI_link_ST, tx_frm_offset, link_detect_locked,
    input  tx_frame_type, tx_frame_sw_reset, frame_boundary,
           detect_frm_cnt, speed_frm_cnt,
           transmited_255_detect_frm, transmited_7_speed_frm,
           link_speed_timeout_detect
  );
endinterface

// File: rtl/mgmt_phy_frm_counter.sv
// Purpose : saturating frame counter with synchronous clear and a registered
//           target-reached flag.
// Ports   : clk, rst_n (async active-low), i_clr (clear, wins over
//           increment), i_inc (count one frame), o_cnt (count), o_done
//           (count == TARGET, one cycle behind the count).
module mgmt_phy_frm_counter #(
  parameter int unsigned   W      = 8,
  parameter logic [W-1:0]  TARGET = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_done
);

  logic [W-1:0] r_cnt;
  logic         r_done;

  // Count frames, stop at TARGET, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_cnt == TARGET);
      if (i_clr)
        r_cnt <= '0;
      else if (i_inc && (r_cnt != TARGET))
        r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = r_done;

endmodule

// File: rtl/mgmt_phy_tx_scheduler.sv
// Purpose : controller-side LTPI TX frame scheduler. Picks the next frame
//           type from the link state, switching only on frame boundaries,
//           counts detect/speed frames and times out the speed phase.
// Ports   : clk, reset_n (async active-low), bus (slave modport of
//           mgmt_phy_tx_scheduler_if carrying state, offset, lock and all
//           scheduler outputs).
module mgmt_phy_tx_scheduler
  import mgmt_phy_tx_scheduler_pkg::*;
#(
  parameter logic [OFFSET_W-1:0]     FRAME_LENGTH     = frame_length,
  parameter logic [DETECT_CNT_W-1:0] DETECT_TX_TARGET = mgmt_phy_tx_scheduler_pkg::DETECT_TX_TARGET,
  parameter logic [SPEED_CNT_W-1:0]  SPEED_TX_TARGET  = mgmt_phy_tx_scheduler_pkg::SPEED_TX_TARGET,
  parameter logic [TMO_CNT_W-1:0]    SPEED_TIMEOUT    = TIMER_1MS_60MHZ
) (
  input  logic                     clk,
  input  logic                     reset_n,
  mgmt_phy_tx_scheduler_if.slave   bus
);

  tx_frm_type_t         r_type;
  tx_frm_type_t         w_next_type;
  logic                 w_load_type;
  logic                 r_sw_reset;
  logic                 w_boundary;
  logic                 w_in_speed;
  logic                 w_det_inc;
  logic                 w_det_clr;
  logic                 w_spd_inc;
  logic                 w_spd_clr;
  logic [TMO_CNT_W-1:0] r_tmo_cnt;
  logic [TMO_CNT_W-1:0] w_tmo_nxt;
  logic                 r_tmo_flag;

  assign w_boundary = (bus.tx_frm_offset == FRAME_LENGTH);
  assign w_in_speed = (bus.LTPI_link_ST == ST_WAIT_LINK_SPEED_LOCKED);

  // State to frame-type map; INIT and SPEED_CHANGE bypass the boundary wait
  // because the PLL is being reprogrammed and the current frame is moot.
  always_comb begin
    w_next_type = FRM_DETECT;
    w_load_type = w_boundary;
    case (bus.LTPI_link_ST)
      ST_INIT: begin
        w_next_type = FRM_DETECT;
        w_load_type = 1'b1;
      end
      ST_COMMA_HUNTING,
      ST_WAIT_LINK_DETECT_LOCKED,
      ST_LINK_LOST_ERR:              w_next_type = FRM_DETECT;
      ST_WAIT_LINK_SPEED_LOCKED:     w_next_type = FRM_SPEED;
      ST_LINK_SPEED_CHANGE: begin
        w_next_type = FRM_IDLE;
        w_load_type = 1'b1;
      end
      ST_WAIT_LINK_ADVERTISE_LOCKED,
      ST_WAIT_IN_ADVERTISE:          w_next_type = FRM_ADVERTISE;
      ST_CONFIGURATION_OR_ACCEPT:    w_next_type = FRM_CONFIGURE;
      ST_OPERATIONAL,
      ST_OPERATIONAL_RESET:          w_next_type = FRM_OPERATIONAL;
      default:                       w_next_type = FRM_DETECT;
    endcase
  end

  // Frame type and sw-reset bit, held for whole frames
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_type     <= FRM_DETECT;
      r_sw_reset <= 1'b0;
    end else begin
      if (w_load_type)
        r_type <= w_next_type;
      if (w_boundary)
        r_sw_reset <= (bus.LTPI_link_ST == ST_OPERATIONAL_RESET);
    end
  end

  // Detect frames count only while remote detect is locked
  assign w_det_inc = w_boundary && (r_type == FRM_DETECT) && bus.link_detect_locked;
  assign w_det_clr = !bus.link_detect_locked || (bus.LTPI_link_ST == ST_INIT);

  // Speed count survives into SPEED_CHANGE so the controller can still see it
  assign w_spd_inc = w_boundary && (r_type == FRM_SPEED);
  assign w_spd_clr = !w_in_speed && (bus.LTPI_link_ST != ST_LINK_SPEED_CHANGE);

  mgmt_phy_frm_counter #(
    .W      (DETECT_CNT_W),
    .TARGET (DETECT_TX_TARGET)
  ) u_detect_cnt (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_clr  (w_det_clr),
    .i_inc  (w_det_inc),
    .o_cnt  (bus.detect_frm_cnt),
    .o_done (bus.transmited_255_detect_frm)
  );

  mgmt_phy_frm_counter #(
    .W      (SPEED_CNT_W),
    .TARGET (SPEED_TX_TARGET)
  ) u_speed_cnt (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_clr  (w_spd_clr),
    .i_inc  (w_spd_inc),
    .o_cnt  (bus.speed_frm_cnt),
    .o_done (bus.transmited_7_speed_frm)
  );

  // Speed-phase timer; flag rises together with count == SPEED_TIMEOUT-1,
  // count parks there so the flag stays sticky until the state is left.
  assign w_tmo_nxt = r_tmo_cnt + TMO_CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt  <= '0;
      r_tmo_flag <= 1'b0;
    end else if (!w_in_speed) begin
      r_tmo_cnt  <= '0;
      r_tmo_flag <= 1'b0;
    end else if (r_tmo_cnt != (SPEED_TIMEOUT - TMO_CNT_W'(1))) begin
      r_tmo_cnt  <= w_tmo_nxt;
      r_tmo_flag <= r_tmo_flag || (w_tmo_nxt == (SPEED_TIMEOUT - TMO_CNT_W'(1)));
    end
  end

  assign bus.tx_frame_type             = r_type;
  assign bus.tx_frame_sw_reset         = r_sw_reset;
  assign bus.frame_boundary            = w_boundary;
  assign bus.link_speed_timeout_detect = r_tmo_flag;

endmodule

// File: tb/tb_mgmt_phy_tx_scheduler.sv
// Purpose : self-checking bench for mgmt_phy_tx_scheduler: a state-to-frame
//           table plus directed multi-cycle sequences (detect/speed counting,
//           lock loss, boundary-aligned switching, timeout, sw-reset, reset).
module tb_mgmt_phy_tx_scheduler;
  import mgmt_phy_tx_scheduler_pkg::*;

  localparam logic [15:0] TB_TIMEOUT = 16'd1000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mgmt_phy_tx_scheduler_if bif();

  mgmt_phy_tx_scheduler #(
    .FRAME_LENGTH     (4'd15),
    .DETECT_TX_TARGET (8'd255),
    .SPEED_TX_TARGET  (3'd7),
    .SPEED_TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    rstate_t      st;
    tx_frm_type_t ty;
    logic         sw;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock; framer advances its byte offset just after the edge
  task automatic step();
    @(posedge clk);
    #1;
    bif.tx_frm_offset = bif.tx_frm_offset + 4'd1;
    #1;
  endtask

  task automatic run_to_off(input logic [3:0] v);
    for (int i = 0; i < 16; i++) begin
      if (bif.tx_frm_offset == v) break;
      step();
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n * 16; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;

    tbl[0]  = '{ST_WAIT_LINK_SPEED_LOCKED,     FRM_SPEED,       1'b0};
    tbl[1]  = '{ST_COMMA_HUNTING,              FRM_DETECT,      1'b0};
    tbl[2]  = '{ST_WAIT_LINK_ADVERTISE_LOCKED, FRM_ADVERTISE,   1'b0};
    tbl[3]  = '{ST_WAIT_LINK_DETECT_LOCKED,    FRM_DETECT,      1'b0};
    tbl[4]  = '{ST_WAIT_IN_ADVERTISE,          FRM_ADVERTISE,   1'b0};
    tbl[5]  = '{ST_LINK_LOST_ERR,              FRM_DETECT,      1'b0};
    tbl[6]  = '{ST_CONFIGURATION_OR_ACCEPT,    FRM_CONFIGURE,   1'b0};
    tbl[7]  = '{ST_INIT,                       FRM_DETECT,      1'b0};
    tbl[8]  = '{ST_OPERATIONAL,                FRM_OPERATIONAL, 1'b0};
    tbl[9]  = '{rstate_t'(4'd12),              FRM_DETECT,      1'b0};
    tbl[10] = '{ST_LINK_SPEED_CHANGE,          FRM_IDLE,        1'b0};
    tbl[11] = '{rstate_t'(4'd15),              FRM_DETECT,      1'b0};
    tbl[12] = '{ST_OPERATIONAL_RESET,          FRM_OPERATIONAL, 1'b1};
    tbl[13] = '{ST_CONFIGURATION_OR_ACCEPT,    FRM_CONFIGURE,   1'b0};
    tbl[14] = '{ST_OPERATIONAL_RESET,          FRM_OPERATIONAL, 1'b1};

    // Reset, release in COMMA_HUNTING, one full frame of offsets
    rst_n                  = 1'b0;
    bif.LTPI_link_ST       = ST_COMMA_HUNTING;
    bif.tx_frm_offset      = 4'd0;
    bif.link_detect_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_type", int'(bif.tx_frame_type), int'(FRM_DETECT));
    chk("rst_det_cnt", int'(bif.detect_frm_cnt), 0);
    chk("rst_spd_cnt", int'(bif.speed_frm_cnt), 0);
    chk("rst_flags", int'({bif.tx_frame_sw_reset, bif.transmited_255_detect_frm,
                          bif.transmited_7_speed_frm, bif.link_speed_timeout_detect}), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("boundary", int'(bif.frame_boundary), int'(bif.tx_frm_offset == 4'd15));
      step();
      chk("hunt_type", int'(bif.tx_frame_type), int'(FRM_DETECT));
      chk("hunt_cnt", int'(bif.detect_frm_cnt) + int'(bif.speed_frm_cnt), 0);
      chk("hunt_flags", int'({bif.transmited_255_detect_frm, bif.transmited_7_speed_frm,
                             bif.link_speed_timeout_detect}), 0);
    end

    // 255 locked detect frames, flag one cycle later, saturation on the 256th
    bif.LTPI_link_ST       = ST_WAIT_LINK_DETECT_LOCKED;
    bif.link_detect_locked = 1'b1;
    frames(255);
    chk("det_cnt_255", int'(bif.detect_frm_cnt), 255);
    chk("det_flag_lag", int'(bif.transmited_255_detect_frm), 0);
    step();
    chk("det_flag_set", int'(bif.transmited_255_detect_frm), 1);
    frames(1);
    chk("det_cnt_sat", int'(bif.detect_frm_cnt), 255);
    chk("det_flag_hold", int'(bif.transmited_255_detect_frm), 1);

    // Lock loss clears the saturated count, flag follows a cycle later
    bif.link_detect_locked = 1'b0;
    step();
    chk("det_clr_sat", int'(bif.detect_frm_cnt), 0);
    step();
    chk("det_flag_clr", int'(bif.transmited_255_detect_frm), 0);

    // Lock drop at count 100 mid-frame, relock, drop on a boundary
    run_to_off(4'd0);
    bif.link_detect_locked = 1'b1;
    frames(100);
    run_to_off(4'd5);
    chk("det_cnt_100", int'(bif.detect_frm_cnt), 100);
    bif.link_detect_locked = 1'b0;
    step();
    chk("det_drop_mid", int'(bif.detect_frm_cnt), 0);
    run_to_off(4'd0);
    bif.link_detect_locked = 1'b1;
    frames(3);
    chk("det_relock", int'(bif.detect_frm_cnt), 3);
    run_to_off(4'd15);
    bif.link_detect_locked = 1'b0;
    step();
    chk("det_drop_bnd", int'(bif.detect_frm_cnt), 0);

    // Speed phase entered at offset 5: switch waits for the boundary
    run_to_off(4'd5);
    bif.LTPI_link_ST = ST_WAIT_LINK_SPEED_LOCKED;
    step();
    chk("spd_wait_mid", int'(bif.tx_frame_type), int'(FRM_DETECT));
    run_to_off(4'd15);
    chk("spd_wait_last", int'(bif.tx_frame_type), int'(FRM_DETECT));
    step();
    chk("spd_switch", int'(bif.tx_frame_type), int'(FRM_SPEED));
    chk("spd_cnt_0", int'(bif.speed_frm_cnt), 0);
    frames(7);
    chk("spd_cnt_7", int'(bif.speed_frm_cnt), 7);
    chk("spd_flag_lag", int'(bif.transmited_7_speed_frm), 0);
    step();
    chk("spd_flag_set", int'(bif.transmited_7_speed_frm), 1);
    frames(1);
    chk("spd_cnt_sat", int'(bif.speed_frm_cnt), 7);
    chk("spd_no_tmo", int'(bif.link_speed_timeout_detect), 0);

    // Speed change loads IDLE immediately and keeps the speed count
    bif.LTPI_link_ST = ST_LINK_SPEED_CHANGE;
    step();
    chk("chg_idle_now", int'(bif.tx_frame_type), int'(FRM_IDLE));
    chk("chg_cnt_kept", int'(bif.speed_frm_cnt), 7);
    bif.LTPI_link_ST = ST_LINK_LOST_ERR;
    step();
    chk("lost_spd_clr", int'(bif.speed_frm_cnt), 0);
    chk("lost_type_hold", int'(bif.tx_frame_type), int'(FRM_IDLE));
    run_to_off(4'd15);
    step();
    chk("lost_detect", int'(bif.tx_frame_type), int'(FRM_DETECT));

    // Timeout: flag rises after TB_TIMEOUT-1 cycles in the speed state
    bif.LTPI_link_ST = ST_WAIT_LINK_SPEED_LOCKED;
    for (int i = 0; i < int'(TB_TIMEOUT) - 2; i++) step();
    chk("tmo_early", int'(bif.link_speed_timeout_detect), 0);
    step();
    chk("tmo_set", int'(bif.link_speed_timeout_detect), 1);
    repeat (5) step();
    chk("tmo_sticky", int'(bif.link_speed_timeout_detect), 1);
    bif.LTPI_link_ST = ST_LINK_LOST_ERR;
    step();
    chk("tmo_clr", int'(bif.link_speed_timeout_detect), 0);

    // Operational reset: sw_reset for exactly one frame, then advertise
    bif.LTPI_link_ST = ST_OPERATIONAL;
    run_to_off(4'd15);
    step();
    chk("op_type", int'(bif.tx_frame_type), int'(FRM_OPERATIONAL));
    run_to_off(4'd3);
    bif.LTPI_link_ST = ST_OPERATIONAL_RESET;
    step();
    chk("swr_mid", int'(bif.tx_frame_sw_reset), 0);
    run_to_off(4'd15);
    chk("swr_last", int'(bif.tx_frame_sw_reset), 0);
    step();
    chk("swr_set", int'(bif.tx_frame_sw_reset), 1);
    bif.LTPI_link_ST = ST_WAIT_LINK_ADVERTISE_LOCKED;
    run_to_off(4'd15);
    chk("swr_held", int'(bif.tx_frame_sw_reset), 1);
    chk("adv_wait", int'(bif.tx_frame_type), int'(FRM_OPERATIONAL));
    step();
    chk("swr_clr", int'(bif.tx_frame_sw_reset), 0);
    chk("adv_type", int'(bif.tx_frame_type), int'(FRM_ADVERTISE));

    // INIT loads DETECT mid-frame
    run_to_off(4'd5);
    bif.LTPI_link_ST = ST_INIT;
    step();
    chk("init_now", int'(bif.tx_frame_type), int'(FRM_DETECT));

    // State-to-frame table, each applied on a boundary
    for (int i = 0; i < 15; i++) begin
      run_to_off(4'd15);
      bif.LTPI_link_ST = tbl[i].st;
      step();
      chk($sformatf("tbl%0d_type", i), int'(bif.tx_frame_type), int'(tbl[i].ty));
      chk($sformatf("tbl%0d_swr", i), int'(bif.tx_frame_sw_reset), int'(tbl[i].sw));
    end

    // Reset in the middle of an operational-reset frame
    run_to_off(4'd7);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_type", int'(bif.tx_frame_type), int'(FRM_DETECT));
    chk("mrst_swr", int'(bif.tx_frame_sw_reset), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bif.LTPI_link_ST = ST_COMMA_HUNTING;
    run_to_off(4'd15);
    step();
    chk("mrst_restart", int'(bif.tx_frame_type), int'(FRM_DETECT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mgmt_phy_tx_scheduler.md
Name: mgmt_phy_tx_scheduler

Overview:
- Controller-side TX frame scheduler for LTPI PHY management.
- Tracks the link training state and selects the frame type the TX framer sends next: detect, speed, advertise, configure, operational or idle.
- Changes frame type only on frame boundaries.
- Counts transmitted detect and speed frames, and generates the speed-phase timeout consumed by the PHY controller state machine.

Parameters:
- FRAME_LENGTH, 4'd15: tx_frm_offset value of the last byte of a frame.
- DETECT_TX_TARGET, 8'd255: locked detect frames to send before the speed phase.
- SPEED_TX_TARGET, 3'd7: speed frames to send before the speed change.
- SPEED_TIMEOUT, TIMER_1MS_60MHZ: clock cycles allowed in ST_WAIT_LINK_SPEED_LOCKED.

Ports:
- clk  in  1  PHY management clock.
- reset_n  in  1  Asynchronous active-low reset.
- LTPI_link_ST  in  rstate_t  Current PHY controller state.
- tx_frm_offset  in  4  Byte offset of the frame the framer is currently sending.
- link_detect_locked  in  1  Remote detect frames are locked.
- tx_frame_type  out  tx_frm_type_t  Frame type for the current or next frame.
- tx_frame_sw_reset  out  1  Set the software-reset bit in operational frames.
- frame_boundary  out  1  Combinational: tx_frm_offset == FRAME_LENGTH.
- detect_frm_cnt  out  8  Locked detect frames sent.
- speed_frm_cnt  out  3  Speed frames sent.
- transmited_255_detect_frm  out  1  detect_frm_cnt == DETECT_TX_TARGET.
- transmited_7_speed_frm  out  1  speed_frm_cnt == SPEED_TX_TARGET.
- link_speed_timeout_detect  out  1  Speed-phase timeout, sticky within the phase.

Behaviour:
- Reset values: tx_frame_type = FRM_DETECT; counters = 0; all flags = 0.
- State to frame-type map (combinational next_type):
  - ST_INIT, ST_COMMA_HUNTING, ST_WAIT_LINK_DETECT_LOCKED, ST_LINK_LOST_ERR -> FRM_DETECT.
  - ST_WAIT_LINK_SPEED_LOCKED -> FRM_SPEED.
  - ST_LINK_SPEED_CHANGE -> FRM_IDLE.
  - ST_WAIT_LINK_ADVERTISE_LOCKED, ST_WAIT_IN_ADVERTISE -> FRM_ADVERTISE.
  - ST_CONFIGURATION_OR_ACCEPT -> FRM_CONFIGURE.
  - ST_OPERATIONAL, ST_OPERATIONAL_RESET -> FRM_OPERATIONAL.
  - Any other state -> FRM_DETECT.
- Frame-type update:
  - tx_frame_type registers next_type only on a clock edge where frame_boundary = 1, so no frame is ever truncated.
  - Exception: ST_INIT and ST_LINK_SPEED_CHANGE load next_type immediately, because the PLL is being reconfigured.
- tx_frame_sw_reset:
  - Registered at the boundary: 1 if LTPI_link_ST == ST_OPERATIONAL_RESET, else 0.
  - Held for exactly one full frame.
- Detect counter:
  - On a boundary, increments if tx_frame_type == FRM_DETECT and link_detect_locked = 1.
  - Saturates at DETECT_TX_TARGET.
  - Cleared on the next edge (asynchronous to the frame) when link_detect_locked falls.
  - Cleared when state is ST_INIT.
  - Increment and lock loss on the same edge: clear wins.
- Speed counter:
  - On a boundary, increments if tx_frame_type == FRM_SPEED.
  - Saturates at SPEED_TX_TARGET.
  - Cleared whenever LTPI_link_ST != ST_WAIT_LINK_SPEED_LOCKED and != ST_LINK_SPEED_CHANGE.
- Completion flags (transmited_*): registered compare of the counters; one cycle after the counter reaches target; remain high while saturated.
- Timeout counter (16 bit):
  - Runs only while in ST_WAIT_LINK_SPEED_LOCKED; cleared otherwise.
  - link_speed_timeout_detect asserts on the cycle the count reaches SPEED_TIMEOUT-1, and holds until the state is left.
  - Deasserts the cycle after the state exits.
- Reset mid-frame: all outputs go to reset values immediately; scheduling restarts at FRM_DETECT.

Decomposition:
- ltpi_pkg gains:
  - tx_frm_type_t enum: FRM_DETECT, FRM_SPEED, FRM_ADVERTISE, FRM_CONFIGURE, FRM_OPERATIONAL, FRM_IDLE.
  - Constants DETECT_TX_TARGET and SPEED_TX_TARGET, with the module parameters defaulting to them.
- rstate_t, frame_length and TIMER_1MS_60MHZ are reused from ltpi_pkg.
- One sub-module: mgmt_phy_frm_counter, a saturating counter with increment, clear and target-reached flag. It is instantiated for the detect and speed counts.

Test Plan:
- Reset release in ST_COMMA_HUNTING, offset cycling 0..15 -> tx_frame_type = FRM_DETECT, counters 0, no flags.
- ST_WAIT_LINK_DETECT_LOCKED, link_detect_locked = 1, 255 boundaries -> detect_frm_cnt = 255; transmited_255_detect_frm high one cycle later; a 256th boundary keeps the count at 255.
- link_detect_locked drops at count 100 mid-frame -> count 0 next edge; relock restarts from 0; lock drop coinciding with a boundary -> count 0.
- State changes to ST_WAIT_LINK_SPEED_LOCKED at offset 5 -> type stays FRM_DETECT until offset 15, then FRM_SPEED; 7 boundaries -> transmited_7_speed_frm = 1.
- Hold ST_WAIT_LINK_SPEED_LOCKED for SPEED_TIMEOUT cycles -> link_speed_timeout_detect asserts exactly at count SPEED_TIMEOUT-1; moving to ST_LINK_LOST_ERR clears it the next cycle.
- ST_OPERATIONAL -> ST_OPERATIONAL_RESET at offset 3 -> tx_frame_sw_reset = 1 for exactly one frame starting at the next boundary; ST_WAIT_LINK_ADVERTISE_LOCKED then yields FRM_ADVERTISE with sw_reset 0.
